uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
8N1 UART receiver, LSB first, the counterpart of the team's UART transmitter. Defaults to a 50 MHz clock at 9600 baud. Synchronises the asynchronous serial line, validates the start bit at mid-bit, and samples the data and stop bits at their centres. Delivers each received byte with a one-cycle valid strobe, and flags framing errors. Sits at the chip pin, feeding the host-side byte consumer.

Parameters:
CLKS_PER_BIT, 5208, clock cycles per bit (50,000,000 / 9600); legal values are 4 or more.
HALF_BIT, (CLKS_PER_BIT-1)/2 (integer division), count from start-edge detect to the start-bit centre sample.
CNT_W, $clog2(CLKS_PER_BIT), bit-counter width (13 at default).

Ports:
clk  in  1  system clock; all state on posedge.
rx_rst_n  in  1  reset; asynchronous assert, active-low.
rx_serial_in  in  1  asynchronous serial line; idles high.
rx_data_out  out  8  last good byte; held until the next good frame.
rx_valid  out  1  one-cycle pulse when rx_data_out is updated.
rx_busy  out  1  high while a frame is in progress (any state except IDLE).
rx_frame_err  out  1  one-cycle pulse when the stop-bit sample is 0.

Behaviour:
- Reset (rx_rst_n=0, asynchronous): state=IDLE, clk_count=0, bit_index=0, rx_data_out=8'h00, rx_valid=0, rx_busy=0, rx_frame_err=0. Both synchroniser flops reset to 1, so no false start is seen after reset.
- Synchroniser: 2-flop chain on rx_serial_in; rx_s is the second-flop output. The FSM uses only rx_s. Pin-to-rx_s latency is 2 cycles.
- IDLE:
  - clk_count=0, bit_index=0, rx_busy=0.
  - On rx_s==0, go to START_BIT, with rx_busy=1 from the next cycle. Call this detect edge t0.
- START_BIT:
  - Count up to HALF_BIT.
  - At clk_count==HALF_BIT, sample rx_s.
  - Sample 0: clk_count=0, go to DATA_BITS.
  - Sample 1: glitch; return to IDLE with no strobe.
- DATA_BITS:
  - Count to CLKS_PER_BIT-1, then sample rx_s into shift_reg[bit_index] and clear clk_count.
  - bit_index 0..7; after bit 7, go to STOP_BIT with bit_index=0.
  - Sample n occurs at t0+HALF_BIT+n*CLKS_PER_BIT, for n=1..8.
- STOP_BIT:
  - Count to CLKS_PER_BIT-1, then sample rx_s at t0+HALF_BIT+9*CLKS_PER_BIT.
  - Sample 1: rx_data_out<=shift_reg, rx_valid=1 for exactly the next cycle, go to IDLE.
  - Sample 0: rx_frame_err=1 for exactly the next cycle, rx_data_out unchanged, go to BREAK_WAIT.
- BREAK_WAIT: stay (rx_busy=1) until rx_s==1, then IDLE. A held-low break line therefore yields exactly one frame_err and no repeated frames.
- Back-to-back frames: returning to IDLE at the mid-stop sample leaves about half a bit of margin. A start edge immediately after the stop bit must be caught.
- rx_valid and rx_frame_err are never high in the same cycle. Neither is high while rx_rst_n=0.
- Reset mid-frame: everything clears immediately and the partial byte is discarded. After release, the line must be seen high then low before a new frame starts.
- The counter never exceeds CLKS_PER_BIT-1. Illegal state encodings go to IDLE.

Decomposition:
- Shared package/include: FSM state encoding (IDLE, START_BIT, DATA_BITS, STOP_BIT, BREAK_WAIT; 3-bit) and the default CLKS_PER_BIT for 50 MHz / 9600. The transmitter and this block use the same constants.
- One sub-module: uart_rx_sync, a 2-flop synchroniser with reset value 1, reusable for other asynchronous inputs.

Test Plan:
(Bench uses CLKS_PER_BIT=16, HALF_BIT=7.)
1. Drive frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> rx_data_out=8'hA5, one rx_valid pulse at t0+7+144+1, rx_frame_err stays 0.
2. Pulse the line low for 4 cycles, then high -> no rx_valid and no rx_frame_err; rx_busy high for about 8 cycles, then back to IDLE.
3. Frame 0x3C with the stop bit driven 0, then line high -> rx_frame_err pulses once, rx_data_out keeps its previous value. Line held low for 100 cycles -> rx_busy stays 1 and only one error is reported.
4. Back-to-back 0x00 then 0xFF with no idle gap -> two rx_valid pulses exactly 160 cycles apart, data 8'h00 then 8'hFF.
5. Assert rx_rst_n low during data bit 4 of 0x81 -> outputs go to reset values asynchronously. Then send 0x81 -> received as 8'h81.
6. Loopback from the team's transmitter (same CLKS_PER_BIT) over 256 bytes 0x00..0xFF -> every byte matches, 256 rx_valid pulses, zero frame errors.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared UART constants and FSM encoding, common to the transmitter and receiver.
// Contents: default bit period for a 50 MHz core clock at 9600 baud, and the
//           3-bit receiver state encoding.
package uart_rx_pkg;

  localparam int unsigned CLK_HZ               = 50_000_000;
  localparam int unsigned BAUD                 = 9600;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = CLK_HZ / BAUD;  // 5208

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_BIT  = 3'd1,
    DATA_BITS  = 3'd2,
    STOP_BIT   = 3'd3,
    BREAK_WAIT = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Pin-side serial input and host-side byte output of the UART receiver.
// master: the receiver (consumes rx_serial_in, drives the byte/status outputs).
// slave:  the line driver / byte consumer (drives rx_serial_in, observes outputs).
interface uart_rx_if;
  logic       rx_serial_in;
  logic [7:0] rx_data_out;
  logic       rx_valid;
  logic       rx_busy;
  logic       rx_frame_err;

  modport master (
    input  rx_serial_in,
    output rx_data_out, rx_valid, rx_busy, rx_frame_err
  );

  modport slave (
    output rx_serial_in,
    input  rx_data_out, rx_valid, rx_busy, rx_frame_err
  );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for a single asynchronous input; 2-cycle latency.
// Ports: clk, rst_n (async active-low), async_i (raw input), sync_o (synchronised).
// Both flops reset to RST_VAL so an idle-high line shows no edge after reset.
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first: start validated at mid-bit, data/stop sampled at centres.
// Ports: clk, rx_rst_n (async active-low), bus (uart_rx_if.master: serial in,
//        byte out with one-cycle valid strobe, busy, one-cycle framing-error strobe).
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter  int CLKS_PER_BIT = int'(DEFAULT_CLKS_PER_BIT),
  localparam int HALF_BIT     = (CLKS_PER_BIT - 1) / 2,
  localparam int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic      clk,
  input  logic      rx_rst_n,
  uart_rx_if.master bus
);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_s;
  uart_state_e      state_q,     state_d;
  logic [CNT_W-1:0] clk_count_q, clk_count_d;
  logic [2:0]       bit_index_q, bit_index_d;
  logic [7:0]       shift_q,     shift_d;
  logic [7:0]       data_q,      data_d;
  logic             valid_q,     valid_d;
  logic             ferr_q,      ferr_d;

  uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
    .clk     (clk),
    .rst_n   (rx_rst_n),
    .async_i (bus.rx_serial_in),
    .sync_o  (rx_s)
  );

  always_ff @(posedge clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      state_q     <= IDLE;
      clk_count_q <= '0;
      bit_index_q <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_count_q <= clk_count_d;
      bit_index_q <= bit_index_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      ferr_q      <= ferr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clk_count_d = clk_count_q;
    bit_index_d = bit_index_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    ferr_d      = 1'b0;

    case (state_q)
      IDLE: begin
        clk_count_d = '0;
        bit_index_d = '0;
        if (!rx_s) state_d = START_BIT;
      end

      START_BIT: begin
        if (clk_count_q == CNT_HALF) begin
          clk_count_d = '0;
          // A line back high at mid-start was a glitch, not a frame.
          state_d     = rx_s ? IDLE : DATA_BITS;
        end else begin
          clk_count_d = clk_count_q + 1'b1;
        end
      end

      DATA_BITS: begin
        if (clk_count_q == CNT_LAST) begin
          clk_count_d          = '0;
          shift_d[bit_index_q] = rx_s;
          if (bit_index_q == 3'd7) begin
            bit_index_d = '0;
            state_d     = STOP_BIT;
          end else begin
            bit_index_d = bit_index_q + 3'd1;
          end
        end else begin
          clk_count_d = clk_count_q + 1'b1;
        end
      end

      STOP_BIT: begin
        if (clk_count_q == CNT_LAST) begin
          clk_count_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            // Hold off in BREAK_WAIT so a held-low line reports a single error.
            ferr_d  = 1'b1;
            state_d = BREAK_WAIT;
          end
        end else begin
          clk_count_d = clk_count_q + 1'b1;
        end
      end

      BREAK_WAIT: begin
        clk_count_d = '0;
        if (rx_s) state_d = IDLE;
      end

      default: begin
        state_d     = IDLE;
        clk_count_d = '0;
        bit_index_d = '0;
      end
    endcase
  end

  assign bus.rx_data_out  = data_q;
  assign bus.rx_valid     = valid_q;
  assign bus.rx_frame_err = ferr_q;
  assign bus.rx_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int CPB = 16;

  logic clk      = 1'b0;
  logic rx_rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_if bus ();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rx_rst_n (rx_rst_n),
    .bus      (bus)
  );

  typedef struct packed {
    logic       is_err;
    logic [7:0] dat;
  } exp_t;

  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  int n_valid        = 0;
  int n_ferr         = 0;
  int busy_rise      = 0;
  int busy_fall      = 0;
  int last_valid_cyc = 0;
  int prev_valid_cyc = 0;
  logic prev_busy  = 1'b0;
  logic prev_valid = 1'b0;
  logic prev_ferr  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic is_err, input logic [7:0] d);
    exp_t e;
    e.is_err = is_err;
    e.dat    = d;
    exp_q.push_back(e);
  endtask

  // Monitor / scoreboard: pops one expectation per output strobe.
  always @(negedge clk) begin
    exp_t e;
    if (rx_rst_n) begin
      if (bus.rx_valid && bus.rx_frame_err) begin
        errors++;
        $display("FAIL strobe_overlap: valid and frame_err both high at cycle %0d", cyc);
      end
      if ((bus.rx_valid && prev_valid) || (bus.rx_frame_err && prev_ferr)) begin
        errors++;
        $display("FAIL strobe_width: strobe longer than one cycle at cycle %0d", cyc);
      end
      if (bus.rx_valid || bus.rx_frame_err) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: valid=%0b ferr=%0b data=%0h with nothing expected",
                   bus.rx_valid, bus.rx_frame_err, bus.rx_data_out);
        end else begin
          e = exp_q.pop_front();
          check("strobe_kind", 32'(bus.rx_frame_err), 32'(e.is_err));
          check("rx_data_out", 32'(bus.rx_data_out), 32'(e.dat));
        end
        if (bus.rx_valid) begin
          n_valid++;
          prev_valid_cyc = last_valid_cyc;
          last_valid_cyc = cyc;
        end else begin
          n_ferr++;
        end
      end
      if (bus.rx_busy && !prev_busy) busy_rise = cyc;
      if (!bus.rx_busy && prev_busy) busy_fall = cyc;
    end
    prev_busy  = bus.rx_busy;
    prev_valid = bus.rx_valid;
    prev_ferr  = bus.rx_frame_err;
  end

  // Drives the line for n cycles; call aligned 1 time unit after a posedge.
  task automatic drive_bit(input logic v, input int n);
    bus.rx_serial_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
    drive_bit(stop, CPB);
  endtask

  initial begin
    int v0;
    int f0;
    bus.rx_serial_in = 1'b1;
    rx_rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data",  32'(bus.rx_data_out),  32'h00);
    check("rst_valid", 32'(bus.rx_valid),     32'h0);
    check("rst_busy",  32'(bus.rx_busy),      32'h0);
    check("rst_ferr",  32'(bus.rx_frame_err), 32'h0);
    rx_rst_n = 1'b1;
    drive_bit(1'b1, 5);
    check("idle_busy_after_release", 32'(bus.rx_busy), 32'h0);

    // 1: good frame 0xA5, strobe 152 cycles after busy rises.
    push(1'b0, 8'hA5);
    send_frame(8'hA5, 1'b1);
    drive_bit(1'b1, 40);
    check("t1_valid_latency", 32'(last_valid_cyc - busy_rise), 32'd152);
    check("t1_valid_count",   32'(n_valid), 32'd1);
    check("t1_ferr_count",    32'(n_ferr),  32'd0);

    // 2: 4-cycle glitch is rejected at the mid-start sample.
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 40);
    check("t2_busy_len",    32'(busy_fall - busy_rise), 32'd8);
    check("t2_valid_count", 32'(n_valid), 32'd1);
    check("t2_ferr_count",  32'(n_ferr),  32'd0);

    // 3a: stop bit low -> one framing error, data held at 0xA5.
    push(1'b1, 8'hA5);
    send_frame(8'h3C, 1'b0);
    drive_bit(1'b1, 40);
    check("t3a_ferr_count", 32'(n_ferr), 32'd1);
    check("t3a_busy",       32'(bus.rx_busy), 32'h0);

    // 3b: break held low: busy stays, only one error.
    push(1'b1, 8'hA5);
    send_frame(8'h00, 1'b0);
    drive_bit(1'b0, 100);
    check("t3b_busy_in_break", 32'(bus.rx_busy), 32'h1);
    check("t3b_ferr_count",    32'(n_ferr), 32'd2);
    drive_bit(1'b1, 40);
    check("t3b_busy_after",    32'(bus.rx_busy), 32'h0);
    check("t3b_ferr_final",    32'(n_ferr), 32'd2);

    // 4: back-to-back frames, no idle gap.
    push(1'b0, 8'h00);
    push(1'b0, 8'hFF);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    drive_bit(1'b1, 40);
    check("t4_spacing",     32'(last_valid_cyc - prev_valid_cyc), 32'd160);
    check("t4_valid_count", 32'(n_valid), 32'd3);

    // 5: reset in the middle of data bit 4 of 0x81.
    drive_bit(1'b0, CPB);
    drive_bit(1'b1, CPB);
    drive_bit(1'b0, CPB);
    drive_bit(1'b0, CPB);
    drive_bit(1'b0, CPB);
    drive_bit(1'b0, 8);
    check("t5_busy_before_rst", 32'(bus.rx_busy), 32'h1);
    rx_rst_n = 1'b0;
    #1;
    check("t5_rst_data",  32'(bus.rx_data_out),  32'h00);
    check("t5_rst_busy",  32'(bus.rx_busy),      32'h0);
    check("t5_rst_valid", 32'(bus.rx_valid),     32'h0);
    check("t5_rst_ferr",  32'(bus.rx_frame_err), 32'h0);
    bus.rx_serial_in = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rx_rst_n = 1'b1;
    drive_bit(1'b1, 20);
    check("t5_idle_after_rst", 32'(bus.rx_busy), 32'h0);
    push(1'b0, 8'h81);
    send_frame(8'h81, 1'b1);
    drive_bit(1'b1, 40);
    check("t5_valid_count", 32'(n_valid), 32'd4);

    // 6: continuous stream of all 256 byte values.
    v0 = n_valid;
    f0 = n_ferr;
    for (int b = 0; b < 256; b++) begin
      push(1'b0, 8'(b));
      send_frame(8'(b), 1'b1);
    end
    drive_bit(1'b1, 40);
    check("t6_valid_count", 32'(n_valid - v0), 32'd256);
    check("t6_ferr_count",  32'(n_ferr - f0),  32'd0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
